// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the divider-ratio controller: FSM encoding, field widths, ratio normalisation.
package clk_div_ctrl_pkg;

    localparam int DIV_W    = 8;
    localparam int SETTLE_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHK    = 3'd1,
        ST_GATE   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_ACK    = 3'd5,
        ST_REJ    = 3'd6
    } state_t;

    // Ratios of 0 and 1 both mean bypass; keep a single encoding internally.
    function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational grant of the first request after the pointer, zero latency.
// Pointer moves to the grant only when i_upd is high, so a held grant is not consumed.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_upd,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_gnt
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    logic [IDX_W-1:0] w_gnt;

    always_comb begin
        int j;
        w_found = 1'b0;
        w_gnt   = '0;
        j       = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(r_ptr) + k) % N;
            if (!w_found && i_req[IDX_W'(j)]) begin
                w_found = 1'b1;
                w_gnt   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDX_W'(N - 1);
        end else if (i_upd && w_found) begin
            r_ptr <= w_gnt;
        end
    end

    assign o_vld = w_found;
    assign o_gnt = w_gnt;

endmodule

// File: rtl/clk_div_ctrl.sv
// Shares one clock divider among N_REQ requesters; glitch-safe gate/align/load/settle/ungate per change.
// Requests are level-held until ack_o/err_o; not sampled outside IDLE. Range check: CLK_DIV_CTRL_RANGE_CHK_EN.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int          N_REQ      = 4,
    parameter int          SETTLE_CYC = 4,
    parameter logic [7:0]  MAX_DIV    = 8'd64
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic [N_REQ-1:0]     err_o,
    output logic [DIV_W-1:0]     div_data_o,
    output logic                 div_en_o,
    output logic                 gate_o,
    output logic                 busy_o,
    output logic [DIV_W-1:0]     cur_div_o
);

    localparam int IDX_W = $clog2(N_REQ);

`ifdef CLK_DIV_CTRL_RANGE_CHK_EN
    localparam bit RANGE_CHK_EN = 1'b1;
`else
    localparam bit RANGE_CHK_EN = 1'b0;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_gnt;
    logic [DIV_W-1:0]    r_new_div;
    logic [DIV_W-1:0]    r_cur_div;
    logic [DIV_W-1:0]    r_phase;
    logic [DIV_W-1:0]    w_phase_nxt;
    logic [SETTLE_W-1:0] r_settle;

    logic                w_arb_vld;
    logic [IDX_W-1:0]    w_arb_gnt;
    logic [DIV_W-1:0]    w_req_data;
    logic                w_take;
    logic                w_load;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .i_req (req_i),
        .i_upd (w_take),
        .o_vld (w_arb_vld),
        .o_gnt (w_arb_gnt)
    );

    assign w_take = (r_state == ST_IDLE) && w_arb_vld;

    always_comb begin
        w_req_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_gnt == IDX_W'(i)) begin
                w_req_data = req_data_i[8*i +: 8];
            end
        end
    end

    // Mirror of the divider counter; zero marks the last cycle of a divided period.
    assign w_phase_nxt = (r_phase == '0) ? (r_cur_div - DIV_W'(1)) : (r_phase - DIV_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        ack_o       = '0;
        err_o       = '0;
        gate_o      = 1'b1;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                if (RANGE_CHK_EN && (r_new_div > MAX_DIV)) begin
                    w_state_nxt = ST_REJ;
                end else if (r_new_div == r_cur_div) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_GATE;
                end
            end
            ST_GATE: begin
                gate_o = 1'b0;
                // Look one cycle ahead so the load strobe lands on the boundary cycle itself.
                if (w_phase_nxt == '0) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                gate_o      = 1'b0;
                w_load      = 1'b1;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                gate_o = 1'b0;
                if (r_settle == '0) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_o[r_gnt] = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            ST_REJ: begin
                if (RANGE_CHK_EN) begin
                    err_o[r_gnt] = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_new_div <= DIV_W'(1);
        end else if (w_take) begin
            r_gnt     <= w_arb_gnt;
            r_new_div <= norm_div(w_req_data);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_div <= DIV_W'(1);
            r_phase   <= '0;
            r_settle  <= '0;
        end else begin
            r_phase <= w_load ? (r_new_div - DIV_W'(1)) : w_phase_nxt;
            if (w_load) begin
                r_cur_div <= r_new_div;
                r_settle  <= SETTLE_W'(SETTLE_CYC) + {1'b0, r_new_div} - SETTLE_W'(1);
            end else if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
                r_settle <= r_settle - SETTLE_W'(1);
            end
        end
    end

    assign div_en_o   = w_load;
    assign div_data_o = (r_state == ST_LOAD) ? r_new_div : r_cur_div;
    assign busy_o     = (r_state != ST_IDLE);
    assign cur_div_o  = r_cur_div;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl with a behavioural model of the shared divider counter.
module tb_clk_div_ctrl;

    localparam int N  = 4;
    localparam int SC = 4;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0] ack_o;
    logic [N-1:0] err_o;
    logic [7:0]   div_data_o;
    logic         div_en_o;
    logic         gate_o;
    logic         busy_o;
    logic [7:0]   cur_div_o;

    clk_div_ctrl #(.N_REQ(N), .SETTLE_CYC(SC), .MAX_DIV(8'd64)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .div_data_o (div_data_o),
        .div_en_o   (div_en_o),
        .gate_o     (gate_o),
        .busy_o     (busy_o),
        .cur_div_o  (cur_div_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int idx;
        int ratio;
        bit same;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   loads = 0;
    bit   gate_low = 1'b0;
    int   load_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Divider model: reloads ratio-1 at zero, takes a new ratio on the load strobe.
    int m_phase;
    int m_ratio;
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_ratio <= 1;
        end else if (div_en_o) begin
            m_ratio <= int'(div_data_o);
            m_phase <= int'(div_data_o) - 1;
        end else if (m_phase == 0) begin
            m_phase <= m_ratio - 1;
        end else begin
            m_phase <= m_phase - 1;
        end
    end

    always @(negedge clk_i) begin
        exp_t         e;
        logic [N-1:0] want_ack;
        logic [N-1:0] want_err;
        if (!rst_n) begin
            loads    = 0;
            gate_low = 1'b0;
        end else begin
            if (!gate_o) gate_low = 1'b1;
            if (div_en_o) begin
                loads++;
                load_cyc = cyc;
                n_cmp++;
                if (m_phase !== 0) begin
                    n_bad++;
                    $display("FAIL load_align: divider phase %0d at load, want 0", m_phase);
                end
                n_cmp++;
                if (gate_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gate_at_load: gate_o %b, want 0", gate_o);
                end
                if (sb.size() > 0) begin
                    n_cmp++;
                    if (div_data_o !== 8'(sb[0].ratio)) begin
                        n_bad++;
                        $display("FAIL load_data: div_data_o %0d, want %0d", div_data_o, sb[0].ratio);
                    end
                end
            end
            if ((ack_o != '0) || (err_o != '0)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: ack_o %b err_o %b with empty scoreboard", ack_o, err_o);
                end else begin
                    e = sb.pop_front();
                    want_ack = e.err ? '0 : N'(1 << e.idx);
                    want_err = e.err ? N'(1 << e.idx) : '0;
                    n_cmp++;
                    if (ack_o !== want_ack) begin
                        n_bad++;
                        $display("FAIL ack_vec: ack_o %b, want %b", ack_o, want_ack);
                    end
                    n_cmp++;
                    if (err_o !== want_err) begin
                        n_bad++;
                        $display("FAIL err_vec: err_o %b, want %b", err_o, want_err);
                    end
                    n_cmp++;
                    if (cur_div_o !== 8'(e.ratio)) begin
                        n_bad++;
                        $display("FAIL cur_div: cur_div_o %0d, want %0d", cur_div_o, e.ratio);
                    end
                    n_cmp++;
                    if (loads !== ((e.same || e.err) ? 0 : 1)) begin
                        n_bad++;
                        $display("FAIL load_count: %0d loads, want %0d", loads, (e.same || e.err) ? 0 : 1);
                    end
                    n_cmp++;
                    if (gate_low !== !(e.same || e.err)) begin
                        n_bad++;
                        $display("FAIL gating: gate went low %b, want %b", gate_low, !(e.same || e.err));
                    end
                    n_cmp++;
                    if (gate_o !== 1'b1) begin
                        n_bad++;
                        $display("FAIL gate_at_ack: gate_o %b, want 1", gate_o);
                    end
                    if (!e.same && !e.err) begin
                        n_cmp++;
                        if ((cyc - load_cyc) !== (SC + e.ratio + 1)) begin
                            n_bad++;
                            $display("FAIL settle_lat: ack %0d cycles after load, want %0d",
                                     cyc - load_cyc, SC + e.ratio + 1);
                        end
                    end
                    done_cnt++;
                    loads    = 0;
                    gate_low = 1'b0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk_i);
        rst_n = 1'b0;
        req_i = '0;
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    task automatic do_req(input int idx, input int data, input int ratio, input bit same, input bit err);
        exp_t e;
        int   start;
        int   c0;
        @(negedge clk_i);
        #1;
        e = '{idx, ratio, same, err};
        sb.push_back(e);
        start = done_cnt;
        c0    = cyc;
        req_data_i[8*idx +: 8] = 8'(data);
        req_i[idx] = 1'b1;
        for (int t = 0; t < 600 && done_cnt == start; t++) begin
            @(negedge clk_i);
            #1;
        end
        if (done_cnt == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_req%0d: no completion, want ack/err within 600 cycles", idx);
            sb.delete();
        end else if (same) begin
            n_cmp++;
            if ((cyc - c0) !== 2) begin
                n_bad++;
                $display("FAIL same_lat: ack %0d cycles after request, want 2", cyc - c0);
            end
        end
        req_i[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++; if (ack_o !== '0)       begin n_bad++; $display("FAIL rst_ack: %b, want 0", ack_o); end
        n_cmp++; if (err_o !== '0)       begin n_bad++; $display("FAIL rst_err: %b, want 0", err_o); end
        n_cmp++; if (div_data_o !== 8'd1) begin n_bad++; $display("FAIL rst_div_data: %0d, want 1", div_data_o); end
        n_cmp++; if (div_en_o !== 1'b0)  begin n_bad++; $display("FAIL rst_div_en: %b, want 0", div_en_o); end
        n_cmp++; if (gate_o !== 1'b1)    begin n_bad++; $display("FAIL rst_gate: %b, want 1", gate_o); end
        n_cmp++; if (busy_o !== 1'b0)    begin n_bad++; $display("FAIL rst_busy: %b, want 0", busy_o); end
        n_cmp++; if (cur_div_o !== 8'd1) begin n_bad++; $display("FAIL rst_cur_div: %0d, want 1", cur_div_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_change();
        apply_reset();
        do_req(0, 4, 4, 1'b0, 1'b0);
    endtask

    task automatic test_same_value();
        do_req(2, 4, 4, 1'b1, 1'b0);
    endtask

    task automatic test_boundary();
        do_req(1, 5, 5, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk_i);
            do_req(3, (r == 1) ? 5 : 3, (r == 1) ? 5 : 3, 1'b0, 1'b0);
        end
        do_req(0, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_range();
`ifdef CLK_DIV_CTRL_RANGE_CHK_EN
        do_req(1, 100, 1, 1'b0, 1'b1);
`else
        do_req(1, 100, 100, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_contention();
        int start;
        int data[4] = '{2, 3, 5, 6};
        apply_reset();
        @(negedge clk_i);
        #1;
        start = done_cnt;
        for (int i = 0; i < N; i++) begin
            sb.push_back('{i, data[i], 1'b0, 1'b0});
            req_data_i[8*i +: 8] = 8'(data[i]);
        end
        req_i = '1;
        for (int t = 0; t < 800 && done_cnt < start + N; t++) begin
            @(negedge clk_i);
            #1;
            for (int i = 0; i < N; i++) if (ack_o[i]) req_i[i] = 1'b0;
        end
        if (done_cnt < start + N) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_contention: %0d acks, want %0d", done_cnt - start, N);
            sb.delete();
        end
        req_i = '0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk_i);
        #1;
        req_data_i[7:0] = 8'd8;
        req_i[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk_i);
            seen = div_en_o;
        end
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (!seen || busy_o !== 1'b1 || gate_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_settle: load seen %b busy %b gate %b, want 1 1 0", seen, busy_o, gate_o);
        end
        #1;
        rst_n = 1'b0;
        req_i = '0;
        #1;
        n_cmp++; if (gate_o !== 1'b1)    begin n_bad++; $display("FAIL mid_rst_gate: %b, want 1", gate_o); end
        n_cmp++; if (cur_div_o !== 8'd1) begin n_bad++; $display("FAIL mid_rst_cur_div: %0d, want 1", cur_div_o); end
        n_cmp++; if (busy_o !== 1'b0)    begin n_bad++; $display("FAIL mid_rst_busy: %b, want 0", busy_o); end
        n_cmp++; if (div_en_o !== 1'b0)  begin n_bad++; $display("FAIL mid_rst_div_en: %b, want 0", div_en_o); end
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        do_req(2, 3, 3, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_same_value();
        test_boundary();
        test_range();
        test_contention();
        test_reset_mid();
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Controller that shares one programmable clock divider among N_REQ requesters. It arbitrates divide-ratio change requests round-robin and drives the divider's div_data/div_en load port. Each change follows a glitch-safe sequence: gate the divided clock, align to a period boundary, load, settle, ungate. It sits between the software/peripheral config agents and the divider, in the clk_i domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
SETTLE_CYC, 4, extra clk_i cycles waited after load before ungating (1..15)
MAX_DIV, 8'd64, largest legal ratio; used only with the optional feature

Ports:
clk_i  input  1  system clock, same clock as the divider
rst_n  input  1  asynchronous active-low reset
req_i  input  N_REQ  level request per requester; held until matching ack_o
req_data_i  input  8*N_REQ  requested ratio; slice i = [8*i+7:8*i]; stable while req_i[i]=1
ack_o  output  N_REQ  one-cycle completion pulse to the granted requester
err_o  output  N_REQ  one-cycle reject pulse (optional feature only; else tied 0)
div_data_o  output  8  ratio presented to the divider
div_en_o  output  1  one-cycle load strobe to the divider
gate_o  output  1  divided-clock enable; 0 while switching
busy_o  output  1  1 whenever state != IDLE
cur_div_o  output  8  ratio currently in effect

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock clk_i.
- Reset values: ack_o=0, err_o=0, div_data_o=1, div_en_o=0, gate_o=1, busy_o=0, cur_div_o=1, state=IDLE, rr pointer=N_REQ-1, phase_cnt=0.
- Ratio normalisation: captured value 0 is treated as 1 (ratios <=1 mean bypass).
- Phase tracker: phase_cnt mirrors the divider counter; loads cur_div-1 when 0, else decrements every cycle. Boundary = phase_cnt==0.
- Arbitration: in IDLE, when any req_i is high, grant the first asserted index after the rr pointer (wrapping). Captured on that edge: grant index, normalised ratio into new_div, rr pointer := grant. Requests are not sampled outside IDLE.
- States:
  IDLE -> CHK on any request.
  CHK (1 cycle): if new_div==cur_div -> ACK (no gating); else -> GATE.
  GATE: gate_o=0; stay until phase_cnt==0; then -> LOAD.
  LOAD (1 cycle): div_en_o=1, div_data_o=new_div; cur_div_o updated to new_div at end of cycle; phase_cnt reloads new_div-1; -> SETTLE.
  SETTLE: counter loaded with SETTLE_CYC+new_div-1 (9-bit), decrements; at 0 -> ACK.
  ACK (1 cycle): gate_o=1, ack_o[grant]=1; -> IDLE.
- Latency: same-value request acks 2 cycles after the grant edge. Changed request acks after 2 + boundary wait + 1 + (SETTLE_CYC+new_div) cycles.
- After ACK, IDLE lasts at least 1 cycle. The requester must drop req_i on seeing ack_o; a request still high is re-arbitrated as new.
- A requester that drops req_i mid-sequence does not abort it; the sequence finishes and ack_o still pulses.
- Simultaneous requests: strict round-robin, so no requester is granted twice while another is pending.
- Reset mid-operation: everything returns to reset values immediately; gate_o=1; the divider reset restores ratio 1 consistently.
- div_data_o holds its last loaded value between loads.

Optional Feature:
CLK_DIV_CTRL_RANGE_CHK_EN:
- Defined: in CHK, new_div > MAX_DIV -> REJ state (1 cycle): err_o[grant]=1, no ack_o, no gating, cur_div unchanged -> IDLE.
- Undefined: no check; err_o tied 0; all 8-bit values accepted.

Decomposition:
- Shared package/include clk_div_ctrl_pkg.vh: state encodings (IDLE, CHK, GATE, LOAD, SETTLE, ACK, REJ), DIV_W=8, SETTLE_W=9.
- One sub-module: rr_arbiter (N_REQ-wide round-robin, combinational grant plus registered pointer), reusable elsewhere.

Test Plan:
- Reset: rst_n low mid-SETTLE -> gate_o=1, cur_div_o=1, busy_o=0, div_en_o=0 within the reset assertion.
- Single change: req_i[0], data 4, from cur_div 1 -> one div_en_o pulse with div_data_o=4; gate_o low from GATE to ACK; ack_o[0] 9 cycles after LOAD (SETTLE_CYC=4); cur_div_o=4.
- Same value: cur_div 4, req_i[2] data 4 -> no div_en_o, gate_o stays 1, ack_o[2] 2 cycles after grant.
- Contention: req_i=4'b1111 held, rr ptr 3 -> grants 0,1,2,3 in order with data 2,3,5,6; each ack single-cycle; no overlap.
- Boundary alignment: cur_div 5, request 3 issued at random phase -> div_en_o coincides with phase_cnt==0; data 0 -> treated as 1, cur_div_o=1.
- Range check (macro defined, MAX_DIV=64): data 100 -> err_o pulse, no div_en_o, cur_div unchanged; macro undefined -> loads 100 and acks.
